ans_stream_decoder: RTL and testbench
=====================================

// Module: ans_stream_decoder
// PURPOSE
//   Parametrised next-generation ANS symbol decoder. Loads a STATE_WIDTH-bit coder state from an
//   IN_WIDTH-bit input stream, then decodes a programmed number of symbols against a static
//   frequency table, renormalising from the stream as needed. Uses a sequential divider,
//   binary-search ICDF lookup, standard valid/ready handshakes, length control and abort.
// PARAMETERS
//   SYM_WIDTH    4   symbol index width; SYM_COUNT = 1<<SYM_WIDTH table entries
//   CNT_WIDTH    8   width of each counts[] entry
//   STATE_WIDTH  32  decoder state width; must be a multiple of IN_WIDTH
//   IN_WIDTH     4   input stream word width
//   LEN_WIDTH    16  width of symbol-count field
//   (derived) CUM_W = CNT_WIDTH+SYM_WIDTH, width of each cumulative[] entry
// PORTS
//   clk           in   1                    clock
//   rst_n         in   1                    reset, asynchronous, active-low
//   start         in   1                    1-cycle pulse in IDLE: begin a decode job
//   abort         in   1                    synchronous: return to IDLE from any state
//   num_syms      in   LEN_WIDTH            symbols to decode; sampled on start
//   counts_flat   in   CNT_WIDTH*SYM_COUNT  counts[s] at [s*CNT_WIDTH +: CNT_WIDTH]
//   cum_flat      in   CUM_W*SYM_COUNT      inclusive cumulative cum[s]=sum counts[0..s]
//   in_data       in   IN_WIDTH             stream word
//   in_valid      in   1                    in_data valid
//   in_ready      out  1                    decoder accepts a word
//   out_sym       out  SYM_WIDTH            decoded symbol
//   out_valid     out  1                    out_sym valid
//   out_ready     in   1                    sink accepts symbol
//   busy          out  1                    high in every state except IDLE
//   done          out  1                    1-cycle pulse: job finished (or rejected)
//   err           out  1                    job rejected because M==0; cleared by next start
// BEHAVIOUR
// - Reset: state IDLE; in_ready=0, out_valid=0, out_sym=0, busy=0, done=0, err=0; x, q, r, count=0.
// - Tables must stay stable while busy; not latched. M = cum[SYM_COUNT-1]. cum_excl(0)=0, else cum[s-1].
// - Word transfer on in_valid&&in_ready; symbol transfer on out_valid&&out_ready. in_ready and
//   out_valid do not depend combinationally on in_valid/out_ready. out_sym stable while out_valid.
// - IDLE: start ignored unless in IDLE. On start: err<=0; num_syms==0 -> done next cycle, stay IDLE;
//   M==0 -> err<=1, done next cycle, stay IDLE; else latch remaining<=num_syms -> LOAD.
// - LOAD: in_ready=1. STATE_WIDTH/IN_WIDTH words, least-significant first: word k -> x[k*IN_WIDTH +:
//   IN_WIDTH]. Accept of last word -> DIV next cycle. Stalls indefinitely without in_valid.
// - DIV: restoring divider, exactly STATE_WIDTH cycles; yields q = x / M, r = x % M -> LOOKUP.
// - LOOKUP: binary search, exactly SYM_WIDTH cycles: s = smallest index with cum[s] > r (always
//   exists since r < M). Zero-count symbols are never selected. -> EMIT.
// - EMIT: out_valid=1, out_sym=s until accepted; on accept out_valid<=0 -> UPDATE.
//   Latency DIV entry to out_valid high: STATE_WIDTH+SYM_WIDTH cycles.
// - UPDATE (1 cycle): x <= q*counts[s] + r - cum_excl(s), computed at STATE_WIDTH+CNT_WIDTH bits,
//   truncated to STATE_WIDTH (cannot overflow for valid tables); remaining <= remaining-1.
//   remaining becomes 0 -> done pulse, IDLE (no renorm, no further input consumed).
//   else x' < M -> RENORM; else -> DIV.
// - RENORM: in_ready=1; each accept x <= (x << IN_WIDTH) | in_data (MSBs discarded); new x >= M -> DIV,
//   else stay RENORM and take another word.
// - abort: highest priority after reset; next cycle IDLE, in_ready=0, out_valid=0, no done pulse,
//   err unchanged; an in-flight transfer in the abort cycle is ignored.
// - start coincident with abort in IDLE: abort wins, job not started.
// - Reset mid-job: all state lost, reset values above; no done.
// TESTING  (SYM_WIDTH=2, CNT_WIDTH=4, STATE_WIDTH=16, IN_WIDTH=4; counts=[1,2,3,2], cum=[1,3,6,8], M=8)
//   1 start num_syms=3, feed 3,2,1,0 (x=0x0123) -> out_sym 2,2,0 then done pulse; in_ready stays 0 after.
//   2 as 1 with num_syms=4 -> after 0, x=5<8: in_ready=1; feed 7 (x=87) -> out_sym 3, done.
//   3 as 1 with out_ready low 20 cycles per symbol -> out_sym held stable, same sequence, no loss.
//   4 start num_syms=0 -> done 1 cycle later, busy never high; all cum=0, num_syms=1 -> err=1, done.
//   5 abort during DIV of symbol 2 -> IDLE next cycle, no done; restart job 1 -> identical output.
//   6 rst_n low mid-LOAD (after 2 words) -> all outputs at reset values; fresh job 1 decodes correctly.

Source files
------------

// File: rtl/ans_stream_decoder.sv
// ans_stream_decoder
//   Streaming ANS symbol decoder. A job loads a STATE_WIDTH-bit coder state from the input
//   stream (least-significant word first), then repeatedly divides the state by the table
//   total M, looks up the symbol owning the remainder slot, hands it out, and advances the
//   state, pulling more stream words whenever the state drops below M.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin a job (honoured only while idle)
//   abort         return to idle from any state, no done pulse
//   num_syms      number of symbols to decode, sampled on start
//   counts_flat   per-symbol frequencies, counts[s] at [s*CNT_WIDTH +: CNT_WIDTH]
//   cum_flat      inclusive cumulative frequencies, cum[s] at [s*CUM_W +: CUM_W]
//   in_data/in_valid/in_ready     input stream handshake
//   out_sym/out_valid/out_ready   decoded symbol handshake
//   busy          high whenever a job is in progress
//   done          one-cycle pulse when a job ends (normally or rejected)
//   err           job rejected because the table total is zero; cleared on next start
module ans_stream_decoder #(
  parameter int unsigned SYM_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned STATE_WIDTH = 32,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned LEN_WIDTH   = 16,
  localparam int unsigned SYM_COUNT  = 1 << SYM_WIDTH,
  localparam int unsigned CUM_W      = CNT_WIDTH + SYM_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [LEN_WIDTH-1:0]           num_syms,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_flat,
  input  logic [CUM_W*SYM_COUNT-1:0]     cum_flat,
  input  logic [IN_WIDTH-1:0]            in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [SYM_WIDTH-1:0]           out_sym,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned WORDS    = STATE_WIDTH / IN_WIDTH;
  localparam int unsigned CNT_BITS = $clog2(STATE_WIDTH + 1);
  localparam int unsigned WIDE_W   = STATE_WIDTH + CNT_WIDTH;
  localparam int unsigned CMP_W    = STATE_WIDTH + CUM_W;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDiv,
    StLookup,
    StEmit,
    StUpdate,
    StRenorm
  } state_e;

  // Table views
  logic [CNT_WIDTH-1:0] counts [SYM_COUNT];
  logic [CUM_W-1:0]     cum    [SYM_COUNT];
  logic [CUM_W-1:0]     m;

  for (genvar g = 0; g < SYM_COUNT; g++) begin : g_tab
    assign counts[g] = counts_flat[g*CNT_WIDTH +: CNT_WIDTH];
    assign cum[g]    = cum_flat[g*CUM_W +: CUM_W];
  end
  assign m = cum[SYM_COUNT-1];

  // State registers
  state_e                 state_q, state_d;
  logic [STATE_WIDTH-1:0] x_q, x_d;
  logic [STATE_WIDTH-1:0] q_q, q_d;
  logic [CUM_W-1:0]       r_q, r_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [SYM_WIDTH-1:0]   lo_q, lo_d;
  logic [SYM_WIDTH-1:0]   hi_q, hi_d;
  logic [SYM_WIDTH-1:0]   sym_q, sym_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  function automatic logic below_m(input logic [STATE_WIDTH-1:0] v);
    return CMP_W'(v) < CMP_W'(m);
  endfunction

  // Restoring divider step. q_q starts out holding the dividend and is shifted left one bit
  // per cycle, so after STATE_WIDTH steps it holds the quotient and r_q the remainder.
  logic [CUM_W:0]         div_shift;
  logic                   div_ge;
  logic [STATE_WIDTH-1:0] div_q;
  logic [CUM_W-1:0]       div_r;

  always_comb begin
    div_shift = {r_q, q_q[STATE_WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, m});
    div_r     = div_ge ? CUM_W'(div_shift - {1'b0, m}) : CUM_W'(div_shift);
    div_q     = {q_q[STATE_WIDTH-2:0], div_ge};
  end

  // Binary search step over [lo, hi] for the first cum[] entry above the remainder.
  // The interval halves exactly each step, so SYM_WIDTH steps leave lo == hi.
  logic [SYM_WIDTH-1:0] mid;
  logic [SYM_WIDTH-1:0] lo_nx;
  logic [SYM_WIDTH-1:0] hi_nx;

  always_comb begin
    mid = SYM_WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
    if (cum[mid] > r_q) begin
      lo_nx = lo_q;
      hi_nx = mid;
    end else begin
      lo_nx = mid + SYM_WIDTH'(1);
      hi_nx = hi_q;
    end
  end

  // State advance: x' = q*f(s) + r - c(s); fits STATE_WIDTH for consistent tables.
  logic [CUM_W-1:0]       cum_excl;
  logic [STATE_WIDTH-1:0] x_upd;

  always_comb begin
    cum_excl = (sym_q == '0) ? '0 : cum[sym_q - SYM_WIDTH'(1)];
    x_upd    = STATE_WIDTH'(WIDE_W'(q_q) * WIDE_W'(counts[sym_q]) + WIDE_W'(r_q)
                            - WIDE_W'(cum_excl));
  end

  // Stream word merge for the initial load and for renormalisation
  logic [STATE_WIDTH-1:0] x_load;
  logic [STATE_WIDTH-1:0] x_shift;

  always_comb begin
    x_load = x_q;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == CNT_BITS'(k)) x_load[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end
    x_shift = (x_q << IN_WIDTH) | STATE_WIDTH'(in_data);
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    q_d         = q_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sym_d       = sym_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            err_d = 1'b0;
            if (num_syms == '0) begin
              done_d = 1'b1;
            end else if (m == '0) begin
              err_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              remaining_d = num_syms;
              cnt_d       = '0;
              state_d     = StLoad;
            end
          end
        end
        StLoad: begin
          if (in_valid) begin
            x_d = x_load;
            if (cnt_q == CNT_BITS'(WORDS - 1)) begin
              q_d     = x_load;
              r_d     = '0;
              cnt_d   = '0;
              state_d = StDiv;
            end else begin
              cnt_d = cnt_q + CNT_BITS'(1);
            end
          end
        end
        StDiv: begin
          q_d = div_q;
          r_d = div_r;
          if (cnt_q == CNT_BITS'(STATE_WIDTH - 1)) begin
            cnt_d   = '0;
            lo_d    = '0;
            hi_d    = SYM_WIDTH'(SYM_COUNT - 1);
            state_d = StLookup;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        StLookup: begin
          lo_d = lo_nx;
          hi_d = hi_nx;
          if (cnt_q == CNT_BITS'(SYM_WIDTH - 1)) begin
            sym_d   = lo_nx;
            cnt_d   = '0;
            state_d = StEmit;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
        StEmit: begin
          if (out_ready) state_d = StUpdate;
        end
        StUpdate: begin
          x_d         = x_upd;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            // Last symbol: finish without pulling any further stream words
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (below_m(x_upd)) begin
            state_d = StRenorm;
          end else begin
            q_d     = x_upd;
            r_d     = '0;
            cnt_d   = '0;
            state_d = StDiv;
          end
        end
        StRenorm: begin
          if (in_valid) begin
            x_d = x_shift;
            if (!below_m(x_shift)) begin
              q_d     = x_shift;
              r_d     = '0;
              cnt_d   = '0;
              state_d = StDiv;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      remaining_q <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      sym_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      q_q         <= q_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sym_q       <= sym_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Handshake outputs depend on state only
  assign in_ready  = (state_q == StLoad) || (state_q == StRenorm);
  assign out_valid = (state_q == StEmit);
  assign out_sym   = sym_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ans_stream_decoder.sv
// tb_ans_stream_decoder
//   Bench for ans_stream_decoder with a 4-symbol table. Directed vectors, hand sequences for
//   abort/reset/error corners, and randomized jobs checked against an arithmetic model.
module tb_ans_stream_decoder;
  localparam int SW = 2, CW = 4, XW = 16, IW = 4, LW = 16, SC = 4, CUMW = 6;
  localparam int LAT = XW + SW + 1;  // negedges from last load word decision to out_valid

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort;
  logic [LW-1:0]     num_syms;
  logic [CW*SC-1:0]  counts_flat;
  logic [CUMW*SC-1:0] cum_flat;
  logic [IW-1:0]     in_data;
  logic              in_valid, in_ready;
  logic [SW-1:0]     out_sym;
  logic              out_valid, out_ready;
  logic              busy, done, err;

  ans_stream_decoder #(
    .SYM_WIDTH(SW), .CNT_WIDTH(CW), .STATE_WIDTH(XW), .IN_WIDTH(IW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_syms(num_syms),
    .counts_flat(counts_flat), .cum_flat(cum_flat), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  nw;
    logic [31:0] w;      // stream words, word k at [4k +: 4]
    logic [3:0]  ne;
    logic [15:0] e;      // expected symbols, symbol j at [2j +: 2]
    logic [7:0]  stall;
  } vec_t;

  vec_t vecs[5];
  int tests_run = 0;
  int fails = 0;
  int tab_cnt[4];
  logic [3:0] stream_q[$];
  int got_q[$];
  int exp_q[$];
  int exp_words;

  task automatic chk(input string name, input int got, input int expv);
    tests_run++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic set_table(input int c0, input int c1, input int c2, input int c3);
    int run;
    run = 0;
    tab_cnt[0] = c0; tab_cnt[1] = c1; tab_cnt[2] = c2; tab_cnt[3] = c3;
    for (int i = 0; i < 4; i++) begin
      run += tab_cnt[i];
      counts_flat[i*CW +: CW]   = CW'(tab_cnt[i]);
      cum_flat[i*CUMW +: CUMW]  = CUMW'(run);
    end
  endtask

  // Reference: plain integer arithmetic straight from the coding rules
  task automatic model(input int num);
    int m, x, k, q, r, s, cumv;
    m = tab_cnt[0] + tab_cnt[1] + tab_cnt[2] + tab_cnt[3];
    x = 0; k = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      x = x | (int'(stream_q[k]) << (4 * i));
      k++;
    end
    for (int n = 0; n < num; n++) begin
      q = x / m; r = x % m;
      s = 0; cumv = tab_cnt[0];
      while (cumv <= r) begin
        s++;
        cumv += tab_cnt[s];
      end
      exp_q.push_back(s);
      x = (q * tab_cnt[s] + r - (cumv - tab_cnt[s])) & 32'hFFFF;
      if (n == num - 1) break;
      while (x < m && k < stream_q.size()) begin
        x = ((x << 4) | int'(stream_q[k])) & 32'hFFFF;
        k++;
      end
    end
    exp_words = k;
  endtask

  // Runs one job: feeds stream_q on demand, collects symbols into got_q.
  task automatic run_job(input int num, input int stall, input bit gaps, output int words_used,
                         output int lat, output bit busy_seen, output bit stable_ok,
                         output bit timed_out, output int cycles);
    int idx, st, since;
    bit have_hold;
    logic [SW-1:0] hold;
    idx = 0; st = 0; since = -1; have_hold = 0; hold = '0;
    lat = -1; busy_seen = 0; stable_ok = 1; timed_out = 0; cycles = 0;
    got_q.delete();
    @(negedge clk);
    num_syms = LW'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (1) begin
      if (busy) busy_seen = 1;
      if (since >= 0) since++;
      if (done) break;
      if (cycles > 3000) begin
        timed_out = 1;
        break;
      end
      cycles++;
      out_ready = 1'b0;
      if (out_valid) begin
        if (lat < 0) lat = since;
        if (have_hold && out_sym !== hold) stable_ok = 0;
        have_hold = 1;
        hold = out_sym;
        if (st < stall) st++;
        else begin
          out_ready = 1'b1;
          got_q.push_back(int'(out_sym));
          st = 0;
          have_hold = 0;
        end
      end
      in_valid = (idx < stream_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
      in_data  = in_valid ? stream_q[idx] : 4'($urandom_range(0, 15));
      if (in_valid && in_ready) begin
        idx++;
        if (idx == 4) since = 0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    words_used = idx;
    cycles = cycles;
  endtask

  task automatic check_quiet(input string name, input int ncyc);
    int bad;
    bad = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (in_ready || busy || out_valid || done) bad++;
    end
    chk(name, bad, 0);
  endtask

  task automatic run_vec(input int i, input string tag);
    int wu, lat, cyc;
    bit bs, so, to;
    set_table(1, 2, 3, 2);
    stream_q.delete();
    for (int k = 0; k < int'(vecs[i].nw); k++) stream_q.push_back(vecs[i].w[k*4 +: 4]);
    run_job(int'(vecs[i].num), int'(vecs[i].stall), 1'b0, wu, lat, bs, so, to, cyc);
    chk({tag, "_timeout"}, int'(to), 0);
    chk({tag, "_nsyms"}, got_q.size(), int'(vecs[i].ne));
    for (int j = 0; j < int'(vecs[i].ne); j++)
      chk($sformatf("%s_sym%0d", tag, j), (j < got_q.size()) ? got_q[j] : -1,
          int'(vecs[i].e[j*2 +: 2]));
    chk({tag, "_words"}, wu, int'(vecs[i].nw));
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_sym_stable"}, int'(so), 1);
    check_quiet({tag, "_idle_after"}, 4);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int wu, lat, cyc, bad, tmp;
    bit bs, so, to;
    vecs[0] = '{num: 16'd3, nw: 4'd4, w: 32'h0000_0123, ne: 4'd3, e: 16'h000A, stall: 8'd0};
    vecs[1] = '{num: 16'd4, nw: 4'd5, w: 32'h0007_0123, ne: 4'd4, e: 16'h00CA, stall: 8'd0};
    vecs[2] = '{num: 16'd3, nw: 4'd4, w: 32'h0000_0123, ne: 4'd3, e: 16'h000A, stall: 8'd20};
    vecs[3] = '{num: 16'd2, nw: 4'd4, w: 32'h0000_8000, ne: 4'd2, e: 16'h0000, stall: 8'd1};
    vecs[4] = '{num: 16'd3, nw: 4'd4, w: 32'h0000_FFFF, ne: 4'd3, e: 16'h003F, stall: 8'd0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_syms = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    set_table(1, 2, 3, 2);
    #22;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_out_sym", int'(out_sym), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: basic decode, renormalisation, output backpressure, edge states
    for (int i = 0; i < 5; i++) run_vec(i, $sformatf("vec%0d", i));

    // Zero-length job: done one cycle after start, never busy
    stream_q.delete();
    run_job(0, 0, 1'b0, wu, lat, bs, so, to, cyc);
    chk("zero_len_done_delay", cyc, 0);
    chk("zero_len_busy", int'(bs), 0);
    chk("zero_len_err", int'(err), 0);

    // Empty table: rejected with err
    set_table(0, 0, 0, 0);
    run_job(1, 0, 1'b0, wu, lat, bs, so, to, cyc);
    chk("empty_tab_done_delay", cyc, 0);
    chk("empty_tab_busy", int'(bs), 0);
    chk("empty_tab_err", int'(err), 1);
    @(negedge clk);
    chk("empty_tab_err_held", int'(err), 1);
    set_table(1, 2, 3, 2);
    run_job(0, 0, 1'b0, wu, lat, bs, so, to, cyc);
    chk("err_cleared_by_start", int'(err), 0);

    // start together with abort in idle: nothing starts
    @(negedge clk);
    num_syms = 16'd3; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(busy), 0);
    check_quiet("start_abort_quiet", 6);

    // Abort during the divide for the second symbol
    @(negedge clk);
    num_syms = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = 4'(3 - k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    tmp = 0;
    while (!out_valid && tmp < 100) begin
      @(negedge clk);
      tmp++;
    end
    chk("abort_first_sym_seen", int'(out_valid), 1);
    chk("abort_first_sym", int'(out_sym), 2);
    out_ready = 1'b1;
    @(negedge clk);  // update
    out_ready = 1'b0;
    @(negedge clk);  // divide, first step
    @(negedge clk);
    chk("abort_pre_busy", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy || out_valid) bad++;
      @(negedge clk);
    end
    chk("abort_no_done", bad, 0);
    chk("abort_err", int'(err), 0);
    run_vec(0, "after_abort");

    // Reset in the middle of loading
    @(negedge clk);
    num_syms = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data = 4'(3 - k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_out_sym", int'(out_sym), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0, "after_reset");

    // Randomized jobs against the model
    for (int t = 0; t < 30; t++) begin
      int c[4], num;
      do begin
        for (int i = 0; i < 4; i++) c[i] = $urandom_range(0, 15);
      end while (c[0] + c[1] + c[2] + c[3] == 0);
      set_table(c[0], c[1], c[2], c[3]);
      num = $urandom_range(1, 8);
      stream_q.delete();
      for (int i = 0; i < 4; i++) stream_q.push_back(4'($urandom_range(0, 15)));
      for (int i = 0; i < 60; i++) stream_q.push_back(4'($urandom_range(1, 15)));
      model(num);
      run_job(num, $urandom_range(0, 2), 1'b1, wu, lat, bs, so, to, cyc);
      chk($sformatf("rnd%0d_timeout", t), int'(to), 0);
      chk($sformatf("rnd%0d_nsyms", t), got_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++)
        chk($sformatf("rnd%0d_sym%0d", t, j), (j < got_q.size()) ? got_q[j] : -1, exp_q[j]);
      chk($sformatf("rnd%0d_words", t), wu, exp_words);
      chk($sformatf("rnd%0d_latency", t), lat, LAT);
      chk($sformatf("rnd%0d_sym_stable", t), int'(so), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
